// File: rtl/alu_share_sched_if.sv
// Bundle of the requester, shared-ALU and response signals of alu_share_sched.
//   slave  : the scheduler side (accepts requests, drives the ALU, returns results)
//   master : the environment side (requesters, the ALU instance, the result consumer)
interface alu_share_sched_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CTL_W  = 4
);
  logic              req0_valid;
  logic              req0_ready;
  logic [CTL_W-1:0]  req0_ctl;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;

  logic              req1_valid;
  logic              req1_ready;
  logic [CTL_W-1:0]  req1_ctl;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;

  logic [CTL_W-1:0]  alu_ctl;
  logic [DATA_W-1:0] alu_in1;
  logic [DATA_W-1:0] alu_in2;
  logic [DATA_W-1:0] alu_out;
  logic              alu_zero;

  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_id;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_zero;
  logic              rsp_err;
  logic              busy;

  modport slave (
    input  req0_valid, req0_ctl, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_ctl, req1_a, req1_b,
    output req1_ready,
    output alu_ctl, alu_in1, alu_in2,
    input  alu_out, alu_zero,
    output rsp_valid, rsp_id, rsp_data, rsp_zero, rsp_err, busy,
    input  rsp_ready
  );

  modport master (
    output req0_valid, req0_ctl, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_ctl, req1_a, req1_b,
    input  req1_ready,
    input  alu_ctl, alu_in1, alu_in2,
    output alu_out, alu_zero,
    input  rsp_valid, rsp_id, rsp_data, rsp_zero, rsp_err, busy,
    output rsp_ready
  );
endinterface

// File: rtl/alu_share_sched.sv
// Shares one external ALU between two requesters. Round-robin arbitration in IDLE,
// one EXEC cycle with registered ALU operands, then the tagged result is held in
// RESP until the consumer takes it. One operation in flight at a time.
// Ports:
//   clk    : clock, rising edge
//   reset  : asynchronous active-high reset
//   bus    : alu_share_sched_if.slave (requesters, shared ALU, response, busy)
module alu_share_sched #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CTL_W  = 4
) (
  input  logic                clk,
  input  logic                reset,
  alu_share_sched_if.slave    bus
);

  localparam logic [CTL_W-1:0] CTL_AND = CTL_W'(4'b0000);
  localparam logic [CTL_W-1:0] CTL_OR  = CTL_W'(4'b0001);
  localparam logic [CTL_W-1:0] CTL_ADD = CTL_W'(4'b0010);
  localparam logic [CTL_W-1:0] CTL_SUB = CTL_W'(4'b0110);
  localparam logic [CTL_W-1:0] CTL_LT  = CTL_W'(4'b0111);
  localparam logic [CTL_W-1:0] CTL_GE  = CTL_W'(4'b1000);
  localparam logic [CTL_W-1:0] CTL_NOR = CTL_W'(4'b1100);
  localparam logic [CTL_W-1:0] CTL_SLL = CTL_W'(4'b1001);
  localparam logic [CTL_W-1:0] CTL_SRL = CTL_W'(4'b1010);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state;
  logic              prio;
  logic [CTL_W-1:0]  op_ctl;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              op_id;
  logic              rsp_valid;
  logic              rsp_id;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_zero;
  logic              rsp_err;
  logic              busy;

  logic              grant_any;
  logic              grant_id;

  function automatic logic ctl_legal(input logic [CTL_W-1:0] c);
    case (c)
      CTL_AND, CTL_OR, CTL_ADD, CTL_SUB, CTL_LT,
      CTL_GE, CTL_NOR, CTL_SLL, CTL_SRL: ctl_legal = 1'b1;
      default:                           ctl_legal = 1'b0;
    endcase
  endfunction

  // Round-robin grant: a lone requester wins outright, a tie goes to prio.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = 1'b0;
    if (state == IDLE) begin
      if (bus.req0_valid && bus.req1_valid) begin
        grant_any = 1'b1;
        grant_id  = prio;
      end else if (bus.req0_valid) begin
        grant_any = 1'b1;
      end else if (bus.req1_valid) begin
        grant_any = 1'b1;
        grant_id  = 1'b1;
      end
    end
  end

  assign bus.req0_ready = grant_any && !grant_id;
  assign bus.req1_ready = grant_any &&  grant_id;

  // The op registers double as the ALU drive, so the ALU inputs hold between ops.
  assign bus.alu_ctl   = op_ctl;
  assign bus.alu_in1   = op_a;
  assign bus.alu_in2   = op_b;

  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_id    = rsp_id;
  assign bus.rsp_data  = rsp_data;
  assign bus.rsp_zero  = rsp_zero;
  assign bus.rsp_err   = rsp_err;
  assign bus.busy      = busy;

  // Scheduler FSM with all state and outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      prio      <= 1'b0;
      op_ctl    <= '0;
      op_a      <= '0;
      op_b      <= '0;
      op_id     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= '0;
      rsp_zero  <= 1'b0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            op_ctl <= grant_id ? bus.req1_ctl : bus.req0_ctl;
            op_a   <= grant_id ? bus.req1_a   : bus.req0_a;
            op_b   <= grant_id ? bus.req1_b   : bus.req0_b;
            op_id  <= grant_id;
            prio   <= ~grant_id;
            busy   <= 1'b1;
            state  <= EXEC;
          end
        end
        EXEC: begin
          // Unsupported codes still drive the ALU but its result is discarded.
          if (ctl_legal(op_ctl)) begin
            rsp_data <= bus.alu_out;
            rsp_zero <= bus.alu_zero;
            rsp_err  <= 1'b0;
          end else begin
            rsp_data <= '0;
            rsp_zero <= 1'b1;
            rsp_err  <= 1'b1;
          end
          rsp_id    <= op_id;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_sched.sv
// Self-checking bench for alu_share_sched: directed ops, scoreboard queue filled at
// accept time, independent monitor popping on every response handshake.
module tb_alu_share_sched;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CTL_W  = 4;

  localparam logic [3:0] C_AND = 4'b0000;
  localparam logic [3:0] C_OR  = 4'b0001;
  localparam logic [3:0] C_ADD = 4'b0010;
  localparam logic [3:0] C_SUB = 4'b0110;
  localparam logic [3:0] C_SLL = 4'b1001;
  localparam logic [3:0] C_BAD = 4'b0011;

  typedef struct packed {
    logic        id;
    logic [31:0] data;
    logic        zero;
    logic        err;
  } rsp_t;

  logic clk;
  logic reset;

  alu_share_sched_if #(.DATA_W(DATA_W), .CTL_W(CTL_W)) bus ();

  alu_share_sched #(.DATA_W(DATA_W), .CTL_W(CTL_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU outside the DUT; unknown codes return a non-zero marker.
  logic [31:0] alu_res;
  always_comb begin
    alu_res = 32'hDEAD_BEEF;
    case (bus.alu_ctl)
      4'b0000: alu_res = bus.alu_in1 & bus.alu_in2;
      4'b0001: alu_res = bus.alu_in1 | bus.alu_in2;
      4'b0010: alu_res = bus.alu_in1 + bus.alu_in2;
      4'b0110: alu_res = bus.alu_in1 - bus.alu_in2;
      4'b0111: alu_res = ($signed(bus.alu_in1) <  $signed(bus.alu_in2)) ? 32'd1 : 32'd0;
      4'b1000: alu_res = ($signed(bus.alu_in1) >= $signed(bus.alu_in2)) ? 32'd1 : 32'd0;
      4'b1100: alu_res = ~(bus.alu_in1 | bus.alu_in2);
      4'b1001: alu_res = bus.alu_in1 << bus.alu_in2[4:0];
      4'b1010: alu_res = bus.alu_in1 >> bus.alu_in2[4:0];
      default: alu_res = 32'hDEAD_BEEF;
    endcase
  end
  assign bus.alu_out  = alu_res;
  assign bus.alu_zero = (alu_res == 32'd0);

  int   n_tests = 0;
  int   n_fail  = 0;
  rsp_t sb[$];

  // Round-robin vectors: requester 0 adds, requester 1 subtracts.
  logic [31:0] t0_a [4] = '{32'd10, 32'd20, 32'd30, 32'd40};
  logic [31:0] t0_b [4] = '{32'd1,  32'd2,  32'd3,  32'd4};
  logic [31:0] e0_d [4] = '{32'd11, 32'd22, 32'd33, 32'd44};
  logic [31:0] t1_a [4] = '{32'd100, 32'd50, 32'd7, 32'd3};
  logic [31:0] t1_b [4] = '{32'd1,   32'd50, 32'd2, 32'd5};
  logic [31:0] e1_d [4] = '{32'd99,  32'd0,  32'd5, 32'hFFFF_FFFE};
  logic        e1_z [4] = '{1'b0, 1'b1, 1'b0, 1'b0};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit id, input logic [3:0] ctl, input logic [31:0] a,
                       input logic [31:0] b, input bit v);
    if (!id) begin
      bus.req0_valid = v; bus.req0_ctl = ctl; bus.req0_a = a; bus.req0_b = b;
    end else begin
      bus.req1_valid = v; bus.req1_ctl = ctl; bus.req1_a = a; bus.req1_b = b;
    end
  endtask

  // Called just after a posedge; returns just after the accept edge (DUT in EXEC).
  task automatic issue(input bit id, input logic [3:0] ctl, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] ed, input bit ez,
                       input bit ee, output int waits);
    bit got;
    waits = 0;
    got   = 1'b0;
    drive(id, ctl, a, b, 1'b1);
    while (!got && waits <= 50) begin
      @(negedge clk);
      if (id ? bus.req1_ready : bus.req0_ready) got = 1'b1;
      else waits++;
    end
    if (!got) begin
      n_tests++; n_fail++;
      $display("FAIL accept_timeout: requester %0d not granted within 50 cycles", id);
      drive(id, 4'hF, '1, '1, 1'b0);
    end else begin
      sb.push_back('{id: id, data: ed, zero: ez, err: ee});
      @(posedge clk); #2;
      // Garbage after accept must not reach the latched operands.
      drive(id, 4'hF, '1, '1, 1'b0);
    end
  endtask

  task automatic load(input bit id, input int i);
    if (i < 4) begin
      if (!id) drive(1'b0, C_ADD, t0_a[i], t0_b[i], 1'b1);
      else     drive(1'b1, C_SUB, t1_a[i], t1_b[i], 1'b1);
    end
  endtask

  // Both requesters held valid; grants must alternate starting at requester 0,
  // one op every 3 cycles while rsp_ready stays high.
  task automatic both_round(input int n_grants);
    int i0, i1, k, n, g, last_n;
    i0 = 0; i1 = 0; k = 0; n = 0; last_n = 0;
    load(1'b0, 0);
    load(1'b1, 0);
    while (k < n_grants && n < 200) begin
      @(negedge clk);
      n++;
      g = -1;
      if (bus.req0_ready)      g = 0;
      else if (bus.req1_ready) g = 1;
      if (g >= 0) begin
        check("grant_order", 64'(g), 64'(k % 2));
        if (k > 0) check("grant_spacing", 64'(n - last_n), 64'd3);
        last_n = n;
        if (g == 0) sb.push_back('{id: 1'b0, data: e0_d[i0 % 4], zero: 1'b0, err: 1'b0});
        else        sb.push_back('{id: 1'b1, data: e1_d[i1 % 4], zero: e1_z[i1 % 4], err: 1'b0});
        k++;
        @(posedge clk); #2;
        if (g == 0) begin i0++; load(1'b0, i0); end
        else        begin i1++; load(1'b1, i1); end
        if (i0 >= 4 || k >= n_grants) bus.req0_valid = 1'b0;
        if (i1 >= 4 || k >= n_grants) bus.req1_valid = 1'b0;
      end
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    if (k < n_grants) begin
      n_tests++; n_fail++;
      $display("FAIL round_timeout: %0d of %0d grants seen", k, n_grants);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while ((bus.busy || sb.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      n_tests++; n_fail++;
      $display("FAIL idle_timeout: busy=%0d pending=%0d", bus.busy, sb.size());
    end
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_busy"},      64'(bus.busy),      64'd0);
    check({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd0);
    check({tag, "_rsp_id"},    64'(bus.rsp_id),    64'd0);
    check({tag, "_rsp_data"},  64'(bus.rsp_data),  64'd0);
    check({tag, "_rsp_zero"},  64'(bus.rsp_zero),  64'd0);
    check({tag, "_rsp_err"},   64'(bus.rsp_err),   64'd0);
    check({tag, "_alu_ctl"},   64'(bus.alu_ctl),   64'd0);
    check({tag, "_alu_in1"},   64'(bus.alu_in1),   64'd0);
    check({tag, "_alu_in2"},   64'(bus.alu_in2),   64'd0);
  endtask

  // Monitor: response stability while stalled and scoreboard compare on handshake.
  bit   hold = 1'b0;
  rsp_t held;
  always @(negedge clk) begin
    rsp_t cur;
    rsp_t exp;
    if (reset) begin
      hold = 1'b0;
    end else begin
      if (bus.req0_ready || bus.req1_ready) begin
        check("ready_one_hot", 64'(bus.req0_ready & bus.req1_ready), 64'd0);
        check("ready_only_idle", 64'(bus.busy), 64'd0);
      end
      if (bus.rsp_valid) begin
        cur = '{id: bus.rsp_id, data: bus.rsp_data, zero: bus.rsp_zero, err: bus.rsp_err};
        if (hold) check("rsp_stable", 64'(cur), 64'(held));
        if (bus.rsp_ready) begin
          if (sb.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL rsp_unexpected: id=%0d data=0x%0h with nothing expected",
                     cur.id, cur.data);
          end else begin
            exp = sb.pop_front();
            check("rsp_id",   64'(cur.id),   64'(exp.id));
            check("rsp_data", 64'(cur.data), 64'(exp.data));
            check("rsp_zero", 64'(cur.zero), 64'(exp.zero));
            check("rsp_err",  64'(cur.err),  64'(exp.err));
          end
          hold = 1'b0;
        end else begin
          hold = 1'b1;
          held = cur;
        end
      end else begin
        hold = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    reset = 1'b1;
    bus.rsp_ready = 1'b1;
    drive(1'b0, 4'h0, '0, '0, 1'b0);
    drive(1'b1, 4'h0, '0, '0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check_cleared("reset");
    check("reset_req0_ready", 64'(bus.req0_ready), 64'd0);
    check("reset_req1_ready", 64'(bus.req1_ready), 64'd0);
    @(posedge clk); #2;
    reset = 1'b0;

    // 1: single add, latency and latched operands.
    issue(1'b0, C_ADD, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0, w);
    check("t1_accept_wait", 64'(w), 64'd0);
    @(negedge clk);
    check("t1_exec_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("t1_exec_busy",      64'(bus.busy),      64'd1);
    check("t1_alu_ctl",        64'(bus.alu_ctl),   64'(C_ADD));
    check("t1_alu_in1",        64'(bus.alu_in1),   64'd5);
    check("t1_alu_in2",        64'(bus.alu_in2),   64'd7);
    @(negedge clk);
    check("t1_rsp_valid_2clk", 64'(bus.rsp_valid), 64'd1);
    wait_idle();
    check("t1_alu_hold_in1",   64'(bus.alu_in1),   64'd5);

    // 2: alternating grants from a fresh prio pointer.
    @(posedge clk); #2;
    reset = 1'b1;
    sb.delete();
    @(posedge clk); #2;
    reset = 1'b0;
    both_round(8);
    wait_idle();

    // 3: stalled response; a pending req0 must wait until after the handshake.
    @(posedge clk); #2;
    bus.rsp_ready = 1'b0;
    issue(1'b1, C_SUB, 32'd9, 32'd9, 32'd0, 1'b1, 1'b0, w);
    drive(1'b0, C_AND, 32'hF0, 32'h3C, 1'b1);
    @(negedge clk);
    @(negedge clk);
    check("t3_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t3_valid_held", 64'(bus.rsp_valid), 64'd1);
      check("t3_no_ready0",  64'(bus.req0_ready), 64'd0);
    end
    @(posedge clk); #2;
    bus.rsp_ready = 1'b1;
    issue(1'b0, C_AND, 32'hF0, 32'h3C, 32'h30, 1'b0, 1'b0, w);
    check("t3_accept_after_handshake", 64'(w), 64'd1);

    // 4: unsupported code, then a legal shift.
    issue(1'b0, C_BAD, 32'd3, 32'd3, 32'd0, 1'b1, 1'b1, w);
    issue(1'b0, C_SLL, 32'd1, 32'd4, 32'd16, 1'b0, 1'b0, w);
    wait_idle();

    // 6: lone req0 with prio=1 is granted immediately.
    @(posedge clk); #2;
    issue(1'b0, C_OR, 32'h0F, 32'hF0, 32'hFF, 1'b0, 1'b0, w);
    check("t6_no_wait", 64'(w), 64'd0);
    wait_idle();

    // 5a: reset during EXEC drops the op.
    @(posedge clk); #2;
    issue(1'b0, C_ADD, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0, w);
    reset = 1'b1;
    #1;
    sb.delete();
    check_cleared("rst_exec");
    @(posedge clk); #2;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_exec_no_rsp", 64'(bus.rsp_valid), 64'd0);
    @(posedge clk); #2;
    both_round(2);
    wait_idle();

    // 5b: reset during RESP drops the held response.
    @(posedge clk); #2;
    bus.rsp_ready = 1'b0;
    issue(1'b0, C_ADD, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0, w);
    @(negedge clk);
    @(negedge clk);
    check("rst_resp_pre_valid", 64'(bus.rsp_valid), 64'd1);
    reset = 1'b1;
    #1;
    sb.delete();
    check_cleared("rst_resp");
    bus.rsp_ready = 1'b1;
    @(posedge clk); #2;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_resp_no_rsp", 64'(bus.rsp_valid), 64'd0);
    @(posedge clk); #2;
    both_round(2);
    wait_idle();

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
